// File: rtl/ps2_mouse_device_sm.sv
// ps2_mouse_device_sm: device-side PS/2 mouse responder.
// Runs the power-on self-test report (AA, 00), answers host commands with
// FA/FE, and streams 3-byte movement packets built from saturating 12-bit
// accumulators. It sits between a byte-level PS/2 device transceiver and a
// movement source.
// Optional build macro: TX_TIMEOUT_EN. When it is defined, every WAIT state
// abandons its transfer after TX_TIMEOUT cycles without TX_BYTE_SENT. When it
// is undefined, WAIT states wait indefinitely.
module ps2_mouse_device_sm #(
    parameter int POR_DELAY  = 500000,
    parameter int PKT_GAP    = 500000,
    parameter int TX_TIMEOUT = 100000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RX_BYTE_READY,
    input  logic [7:0] RX_BYTE,
    input  logic       RX_ERROR,
    output logic       TX_SEND_BYTE,
    output logic [7:0] TX_BYTE,
    input  logic       TX_BYTE_SENT,
    input  logic       MOVE_VALID,
    input  logic [7:0] MOVE_DX,
    input  logic [7:0] MOVE_DY,
    input  logic [2:0] BUTTONS,
    output logic       STREAMING,
    output logic [3:0] CURR_STATE
);

    localparam logic [3:0] S_POR_WAIT = 4'd0;
    localparam logic [3:0] S_SEND_AA  = 4'd1;
    localparam logic [3:0] S_WAIT_AA  = 4'd2;
    localparam logic [3:0] S_SEND_ID  = 4'd3;
    localparam logic [3:0] S_WAIT_ID  = 4'd4;
    localparam logic [3:0] S_IDLE     = 4'd5;
    localparam logic [3:0] S_SEND_RSP = 4'd6;
    localparam logic [3:0] S_WAIT_RSP = 4'd7;
    localparam logic [3:0] S_SEND_PKT = 4'd8;
    localparam logic [3:0] S_WAIT_PKT = 4'd9;

    logic [3:0]  state_q, state_d;
    logic [31:0] por_cnt_q, por_cnt_d;
    logic [31:0] gap_cnt_q, gap_cnt_d;
    logic        tx_send_q, tx_send_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        streaming_q, streaming_d;
    logic        pend_valid_q, pend_valid_d;
    logic [7:0]  pend_byte_q, pend_byte_d;
    logic        pend_err_q, pend_err_d;
    logic [7:0]  rsp_q, rsp_d;
    logic        rst_after_q, rst_after_d;
    logic [1:0]  idx_q, idx_d;
    logic [11:0] acc_x_q, acc_x_d;
    logic [11:0] acc_y_q, acc_y_d;
    logic [2:0]  last_btn_q, last_btn_d;
    logic [7:0]  pkt0_q, pkt0_d;
    logic [7:0]  pkt1_q, pkt1_d;
    logic [7:0]  pkt2_q, pkt2_d;

    logic        snap;
    logic        acc_clr;
    logic        tx_abort;
    logic        cmd_avail;
    logic [7:0]  cmd_byte;
    logic        cmd_err;
    logic [9:0]  clamp_x;
    logic [9:0]  clamp_y;
    logic        gap_expired;
    logic        move_pending;

    // Sign-extend an 8-bit delta onto a 12-bit accumulator, saturating.
    function automatic logic [11:0] sat_add(input logic [11:0] a, input logic [7:0] d);
        logic signed [12:0] s;
        s = $signed({a[11], a}) + $signed({{5{d[7]}}, d});
        if (s > 13'sd2047)
            sat_add = 12'h7FF;
        else if (s < -13'sd2048)
            sat_add = 12'h800;
        else
            sat_add = s[11:0];
    endfunction

    // Clamp an accumulator to [-256, +255]; returns {overflow, 9-bit value}.
    function automatic logic [9:0] clamp9(input logic [11:0] a);
        if ($signed(a) > 12'sd255)
            clamp9 = {1'b1, 9'h0FF};
        else if ($signed(a) < -12'sd256)
            clamp9 = {1'b1, 9'h100};
        else
            clamp9 = {1'b0, a[8:0]};
    endfunction

    assign clamp_x      = clamp9(acc_x_q);
    assign clamp_y      = clamp9(acc_y_q);
    assign gap_expired  = (gap_cnt_q == 32'(PKT_GAP));
    assign move_pending = (acc_x_q != 12'd0) || (acc_y_q != 12'd0) || (BUTTONS != last_btn_q);

    // A byte arriving in IDLE wins over an older latched one.
    assign cmd_avail = RX_BYTE_READY | pend_valid_q;
    assign cmd_byte  = RX_BYTE_READY ? RX_BYTE  : pend_byte_q;
    assign cmd_err   = RX_BYTE_READY ? RX_ERROR : pend_err_q;

`ifdef TX_TIMEOUT_EN
    logic [31:0] to_cnt_q, to_cnt_d;
    logic        in_wait;

    assign in_wait  = (state_q == S_WAIT_AA) || (state_q == S_WAIT_ID) ||
                      (state_q == S_WAIT_RSP) || (state_q == S_WAIT_PKT);
    assign tx_abort = in_wait && !TX_BYTE_SENT && (to_cnt_q >= 32'(TX_TIMEOUT - 1));

    // Watchdog counter: zero outside WAIT states, counts while waiting.
    always_comb begin
        to_cnt_d = 32'd0;
        if (in_wait && !TX_BYTE_SENT)
            to_cnt_d = to_cnt_q + 32'd1;
    end

    // Watchdog register.
    always_ff @(posedge CLK) begin
        if (RESET)
            to_cnt_q <= 32'd0;
        else
            to_cnt_q <= to_cnt_d;
    end
`else
    assign tx_abort = 1'b0;
`endif

    // Main FSM: command decode, packet sequencing, pending-byte latch.
    always_comb begin
        state_d      = state_q;
        por_cnt_d    = por_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        tx_send_d    = 1'b0;
        tx_byte_d    = tx_byte_q;
        streaming_d  = streaming_q;
        pend_valid_d = pend_valid_q;
        pend_byte_d  = pend_byte_q;
        pend_err_d   = pend_err_q;
        rsp_d        = rsp_q;
        rst_after_d  = rst_after_q;
        idx_d        = idx_q;
        last_btn_d   = last_btn_q;
        pkt0_d       = pkt0_q;
        pkt1_d       = pkt1_q;
        pkt2_d       = pkt2_q;
        snap         = 1'b0;
        acc_clr      = 1'b0;

        if (!gap_expired)
            gap_cnt_d = gap_cnt_q + 32'd1;

        // Bytes arriving while busy are held one-deep; the newest one wins.
        if (RX_BYTE_READY && (state_q > S_IDLE)) begin
            pend_valid_d = 1'b1;
            pend_byte_d  = RX_BYTE;
            pend_err_d   = RX_ERROR;
        end

        case (state_q)
            S_POR_WAIT: begin
                pend_valid_d = 1'b0;
                if (por_cnt_q >= 32'(POR_DELAY - 1)) begin
                    por_cnt_d = 32'd0;
                    state_d   = S_SEND_AA;
                end else begin
                    por_cnt_d = por_cnt_q + 32'd1;
                end
            end
            S_SEND_AA: begin
                pend_valid_d = 1'b0;
                tx_send_d    = 1'b1;
                tx_byte_d    = 8'hAA;
                state_d      = S_WAIT_AA;
            end
            S_WAIT_AA: begin
                pend_valid_d = 1'b0;
                if (TX_BYTE_SENT)
                    state_d = S_SEND_ID;
                else if (tx_abort)
                    state_d = S_IDLE;
            end
            S_SEND_ID: begin
                pend_valid_d = 1'b0;
                tx_send_d    = 1'b1;
                tx_byte_d    = 8'h00;
                state_d      = S_WAIT_ID;
            end
            S_WAIT_ID: begin
                pend_valid_d = 1'b0;
                if (TX_BYTE_SENT || tx_abort)
                    state_d = S_IDLE;
            end
            S_IDLE: begin
                if (cmd_avail) begin
                    pend_valid_d = 1'b0;
                    state_d      = S_SEND_RSP;
                    rsp_d        = 8'hFA;
                    rst_after_d  = 1'b0;
                    if (cmd_err) begin
                        rsp_d = 8'hFE;
                    end else begin
                        case (cmd_byte)
                            8'hFF: begin
                                streaming_d = 1'b0;
                                rst_after_d = 1'b1;
                            end
                            8'hF4: streaming_d = 1'b1;
                            8'hF5: begin
                                streaming_d = 1'b0;
                                acc_clr     = 1'b1;
                            end
                            8'hF6: streaming_d = 1'b0;
                            default: rsp_d = 8'hFE;
                        endcase
                    end
                end else if (streaming_q && gap_expired && move_pending) begin
                    snap       = 1'b1;
                    pkt0_d     = {clamp_y[9], clamp_x[9], clamp_y[8], clamp_x[8], 1'b1, BUTTONS};
                    pkt1_d     = clamp_x[7:0];
                    pkt2_d     = clamp_y[7:0];
                    last_btn_d = BUTTONS;
                    idx_d      = 2'd0;
                    state_d    = S_SEND_PKT;
                end
            end
            S_SEND_RSP: begin
                tx_send_d = 1'b1;
                tx_byte_d = rsp_q;
                state_d   = S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                if (TX_BYTE_SENT) begin
                    if (rst_after_q) begin
                        rst_after_d  = 1'b0;
                        pend_valid_d = 1'b0;
                        por_cnt_d    = 32'd0;
                        state_d      = S_POR_WAIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (tx_abort) begin
                    rst_after_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_SEND_PKT: begin
                tx_send_d = 1'b1;
                case (idx_q)
                    2'd0:    tx_byte_d = pkt0_q;
                    2'd1:    tx_byte_d = pkt1_q;
                    default: tx_byte_d = pkt2_q;
                endcase
                state_d = S_WAIT_PKT;
            end
            S_WAIT_PKT: begin
                if (TX_BYTE_SENT) begin
                    // A host byte cuts the packet short after the current byte.
                    if ((idx_q == 2'd2) || pend_valid_q || RX_BYTE_READY) begin
                        idx_d     = 2'd0;
                        gap_cnt_d = 32'd0;
                        state_d   = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_SEND_PKT;
                    end
                end else if (tx_abort) begin
                    idx_d     = 2'd0;
                    gap_cnt_d = 32'd0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d   = S_POR_WAIT;
                por_cnt_d = 32'd0;
            end
        endcase
    end

    // Movement accumulation; a sample in the snapshot cycle lands in the cleared value.
    always_comb begin
        acc_x_d = snap ? 12'd0 : acc_x_q;
        acc_y_d = snap ? 12'd0 : acc_y_q;
        if (acc_clr) begin
            acc_x_d = 12'd0;
            acc_y_d = 12'd0;
        end else if (MOVE_VALID && streaming_q) begin
            acc_x_d = sat_add(acc_x_d, MOVE_DX);
            acc_y_d = sat_add(acc_y_d, MOVE_DY);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= S_POR_WAIT;
            por_cnt_q    <= 32'd0;
            gap_cnt_q    <= 32'd0;
            tx_send_q    <= 1'b0;
            tx_byte_q    <= 8'h00;
            streaming_q  <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_byte_q  <= 8'h00;
            pend_err_q   <= 1'b0;
            rsp_q        <= 8'h00;
            rst_after_q  <= 1'b0;
            idx_q        <= 2'd0;
            acc_x_q      <= 12'd0;
            acc_y_q      <= 12'd0;
            last_btn_q   <= 3'd0;
            pkt0_q       <= 8'h00;
            pkt1_q       <= 8'h00;
            pkt2_q       <= 8'h00;
        end else begin
            state_q      <= state_d;
            por_cnt_q    <= por_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            tx_send_q    <= tx_send_d;
            tx_byte_q    <= tx_byte_d;
            streaming_q  <= streaming_d;
            pend_valid_q <= pend_valid_d;
            pend_byte_q  <= pend_byte_d;
            pend_err_q   <= pend_err_d;
            rsp_q        <= rsp_d;
            rst_after_q  <= rst_after_d;
            idx_q        <= idx_d;
            acc_x_q      <= acc_x_d;
            acc_y_q      <= acc_y_d;
            last_btn_q   <= last_btn_d;
            pkt0_q       <= pkt0_d;
            pkt1_q       <= pkt1_d;
            pkt2_q       <= pkt2_d;
        end
    end

    assign TX_SEND_BYTE = tx_send_q;
    assign TX_BYTE      = tx_byte_q;
    assign STREAMING    = streaming_q;
    assign CURR_STATE   = state_q;

endmodule
